// File: rtl/sr_cond_pkg.sv
// Shared constants and helpers for the SR request conditioner.
package sr_cond_pkg;

  localparam int PRI_SET = 0;
  localparam int PRI_RST = 1;

  // Debounce counter width: max(1, clog2(cycles)).
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sr_cond_channel.sv
// One request channel: synchroniser, debouncer and rising-edge event detector.
module sr_cond_channel
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt;
  logic                   db;
  logic                   db_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised input agrees with db restarts the count,
  // so only an unbroken run of DEBOUNCE_CYCLES mismatches moves db.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      db     <= 1'b0;
      db_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      db_d   <= db;
      if (sync_out == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= sync_out;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign evt = db & ~db_d;

endmodule

// File: rtl/sr_request_conditioner.sv
// Conditions raw set/reset buttons into mutually exclusive one-cycle s/r pulses.
module sr_request_conditioner
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PRIORITY        = PRI_SET
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_rst,
  output logic s,
  output logic r,
  output logic pend_s,
  output logic pend_r
);

  localparam logic RST_FIRST = (PRIORITY == PRI_RST);

  logic evt_s;
  logic evt_r;
  logic grant_s;
  logic grant_r;
  logic defer_q;

  sr_cond_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set (
    .clk(clk),
    .rst(rst),
    .btn(btn_set),
    .evt(evt_s)
  );

  sr_cond_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rst (
    .clk(clk),
    .rst(rst),
    .btn(btn_rst),
    .evt(evt_r)
  );

  // defer_q flips the winner for one cycle after a contested grant, so the
  // losing channel is served next cycle even if the winner re-requests.
  always_comb begin
    grant_s = 1'b0;
    grant_r = 1'b0;
    if (pend_s && pend_r) begin
      if (RST_FIRST ^ defer_q) grant_r = 1'b1;
      else                     grant_s = 1'b1;
    end else begin
      grant_s = pend_s;
      grant_r = pend_r;
    end
  end

  // A new event in the grant cycle keeps the flag set, so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_s  <= 1'b0;
      pend_r  <= 1'b0;
      s       <= 1'b0;
      r       <= 1'b0;
      defer_q <= 1'b0;
    end else begin
      pend_s  <= evt_s | (pend_s & ~grant_s);
      pend_r  <= evt_r | (pend_r & ~grant_r);
      s       <= grant_s;
      r       <= grant_r;
      defer_q <= pend_s & pend_r & ~defer_q;
    end
  end

endmodule

// File: tb/tb_sr_request_conditioner.sv
// Directed and glitch-random bench for sr_request_conditioner, both priorities.
module tb_sr_request_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int LAT  = SYNC + DEB + 2;
  localparam int W    = 34;
  localparam logic [1:0] K_S = 2'b01;
  localparam logic [1:0] K_R = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic s0, r0, ps0, pr0;
  logic s1, r1, ps1, pr1;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // Expected pulses as {cycle, r, s}; queue 0 for set-priority, 1 for reset-priority.
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  sr_request_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .PRIORITY(0)
  ) dut0 (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_rst(btn_rst),
    .s(s0), .r(r0), .pend_s(ps0), .pend_r(pr0)
  );

  sr_request_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .PRIORITY(1)
  ) dut1 (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_rst(btn_rst),
    .s(s1), .r(r1), .pend_s(ps1), .pend_r(pr1)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ev(input int c, input logic [1:0] k);
    return {32'(c), k};
  endfunction

  // Push the pulses expected from rising requests driven in cycle base.
  task automatic expect_rise(input int base, input logic rs, input logic rr);
    if (rs && rr) begin
      exp0_q.push_back(ev(base + LAT, K_S));
      exp0_q.push_back(ev(base + LAT + 1, K_R));
      exp1_q.push_back(ev(base + LAT, K_R));
      exp1_q.push_back(ev(base + LAT + 1, K_S));
    end else if (rs) begin
      exp0_q.push_back(ev(base + LAT, K_S));
      exp1_q.push_back(ev(base + LAT, K_S));
    end else if (rr) begin
      exp0_q.push_back(ev(base + LAT, K_R));
      exp1_q.push_back(ev(base + LAT, K_R));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: exclusivity every cycle, every pulse matched against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      check("excl_p0", W'(s0 & r0), '0);
      check("excl_p1", W'(s1 & r1), '0);
      if (s0 || r0)
        check("pulse_p0", {32'(cyc), r0, s0}, (exp0_q.size() > 0) ? exp0_q.pop_front() : '0);
      if (s1 || r1)
        check("pulse_p1", {32'(cyc), r1, s1}, (exp1_q.size() > 0) ? exp1_q.pop_front() : '0);
    end
  end

  initial begin
    int n;
    logic lvl_s, lvl_r, cur_s, cur_r, fin_s, fin_r;
    int run_s, run_r, g;

    // Reset state before any clock edge.
    #1;
    check("rst_out_p0", W'({s0, r0, ps0, pr0}), '0);
    check("rst_out_p1", W'({s1, r1, ps1, pr1}), '0);
    cycles(3);
    rst = 1'b0;

    // Idle after release.
    cycles(50);
    check("idle_pend", W'({ps0, pr0, ps1, pr1}), '0);

    // Single set request held, then released.
    n = cyc;
    btn_set = 1'b1;
    expect_rise(n, 1'b1, 1'b0);
    cycles(LAT - 2);
    check("pend_s_early", W'(ps0), '0);
    cycles(1);
    check("pend_s_set_p0", W'(ps0), W'(1));
    check("pend_s_set_p1", W'(ps1), W'(1));
    cycles(1);
    check("pend_s_clr", W'(ps0), '0);
    cycles(20);
    btn_set = 1'b0;
    cycles(40);
    check("q_single", W'(exp0_q.size()), '0);

    // Asynchronous reset in the middle of a pulse cycle.
    n = cyc;
    btn_set = 1'b1;
    expect_rise(n, 1'b1, 1'b0);
    cycles(LAT);
    #2 rst = 1'b1;
    #1;
    check("async_rst_p0", W'({s0, r0, ps0, pr0}), '0);
    check("async_rst_p1", W'({s1, r1, ps1, pr1}), '0);
    btn_set = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(30);

    // 5-high/5-low chatter never passes the debouncer.
    for (int i = 0; i < 10; i++) begin
      btn_set = 1'b1;
      cycles(5);
      btn_set = 1'b0;
      cycles(5);
      check("chatter_pend", W'(ps0), '0);
    end
    cycles(30);

    // Simultaneous requests: arbitration order depends on priority.
    n = cyc;
    btn_set = 1'b1;
    btn_rst = 1'b1;
    expect_rise(n, 1'b1, 1'b1);
    cycles(LAT);
    check("both_pend_r_p0", W'(pr0), W'(1));
    check("both_pend_s_p1", W'(ps1), W'(1));
    cycles(40);
    btn_set = 1'b0;
    btn_rst = 1'b0;
    cycles(40);
    check("q_both_p0", W'(exp0_q.size()), '0);
    check("q_both_p1", W'(exp1_q.size()), '0);

    // Reset button held through reset release.
    @(negedge clk);
    rst = 1'b1;
    btn_rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    n = cyc;
    expect_rise(n, 1'b0, 1'b1);
    cycles(LAT + 20);
    check("q_held", W'(exp0_q.size()), '0);
    btn_rst = 1'b0;
    cycles(30);

    // Reset while a request is pending discards it.
    n = cyc;
    btn_rst = 1'b1;
    cycles(LAT - 1);
    check("pend_r_before_rst", W'(pr0), W'(1));
    #2 rst = 1'b1;
    #1;
    check("pend_r_dropped", W'({pr0, pr1}), '0);
    btn_rst = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(40);

    // Random chatter (runs under the debounce length) then a random settled level.
    lvl_s = 1'b0;
    lvl_r = 1'b0;
    for (int seg = 0; seg < 110; seg++) begin
      cur_s = lvl_s;
      cur_r = lvl_r;
      run_s = $urandom_range(1, 12);
      run_r = $urandom_range(1, 12);
      g = $urandom_range(30, 60);
      for (int i = 0; i < g; i++) begin
        btn_set = cur_s;
        btn_rst = cur_r;
        @(negedge clk);
        run_s--;
        run_r--;
        if (run_s == 0) begin
          cur_s = ~cur_s;
          run_s = $urandom_range(1, 12);
        end
        if (run_r == 0) begin
          cur_r = ~cur_r;
          run_r = $urandom_range(1, 12);
        end
      end
      btn_set = lvl_s;
      btn_rst = lvl_r;
      @(negedge clk);
      fin_s = 1'($urandom_range(0, 1));
      fin_r = 1'($urandom_range(0, 1));
      n = cyc;
      btn_set = fin_s;
      btn_rst = fin_r;
      expect_rise(n, fin_s & ~lvl_s, fin_r & ~lvl_r);
      cycles(40);
      lvl_s = fin_s;
      lvl_r = fin_r;
    end

    check("q_final_p0", W'(exp0_q.size()), '0);
    check("q_final_p1", W'(exp1_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
